// File: rtl/regfile_burst_master_pkg.sv
// Shared definitions for the register-file burst master: bus width defaults,
// FSM state encodings and command direction codes.
package regfile_burst_master_pkg;

  localparam int RF_DATA_WIDTH = 24;
  localparam int RF_ADDR_DEPTH = 12;
  localparam int RF_LEN_W      = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/regfile_burst_master_rd_skid.sv
// Two-entry valid/ready buffer catching register-file read data one cycle
// after each issued read; reports occupancy back to the issue logic.
module regfile_burst_master_rd_skid
  import regfile_burst_master_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  pop;

  assign rd_valid  = (count_q != 2'd0);
  assign rd_data   = mem_q[rd_ptr_q];
  assign occupancy = count_q;
  assign pop       = rd_valid && rd_ready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_burst_master.sv
// Burst initiator for the register-file port: one command becomes a run of
// single-cycle accesses. Optional macro: RF_BURST_BOUNDS_CHECK_EN.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a burst command
// WRITE | one rf write per wr handshake until remaining reaches 0
// READ  | issuing rf reads while the skid buffer has room
// DRAIN | all reads issued, waiting for the buffer to empty
// DONE  | one-cycle done (and err) pulse
module regfile_burst_master
  import regfile_burst_master_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_DEPTH = RF_ADDR_DEPTH,
  parameter int LEN_W      = RF_LEN_W
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_DEPTH-1:0] cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_DEPTH-1:0] rf_address,
  output logic                  rf_en_write,
  output logic                  rf_en_read,
  output logic [DATA_WIDTH-1:0] rf_data_in,
  input  logic [DATA_WIDTH-1:0] rf_data_out
);

  state_t                state_q, state_d;
  logic [ADDR_DEPTH-1:0] cur_addr_q;
  logic [LEN_W-1:0]      remaining_q;
  logic                  in_flight_q;
  logic                  out_en_q;
  logic [1:0]            occupancy;
  logic [2:0]            occ_sum;
  logic [2:0]            occ_limit;
  logic                  cmd_fire;
  logic                  wr_fire;
  logic                  rd_pop;
  logic                  rd_issue;
  logic                  bounds_err;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_pop   = rd_valid && rd_ready;

  // A word leaving the buffer this cycle frees its slot for a new issue,
  // which keeps reads at one word per cycle with rd_ready held high.
  assign occ_sum   = {1'b0, occupancy} + {2'b00, in_flight_q};
  assign occ_limit = 3'd2 + {2'b00, rd_pop};

`ifdef RF_BURST_BOUNDS_CHECK_EN
  localparam int SUM_W = ((ADDR_DEPTH > LEN_W) ? ADDR_DEPTH : LEN_W) + 1;
  logic [SUM_W-1:0] burst_end;
  logic             err_q;

  assign burst_end  = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
  assign bounds_err = (burst_end > (SUM_W'(1) << ADDR_DEPTH));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)        err_q <= 1'b0;
    else if (cmd_fire) err_q <= bounds_err;
  end
`else
  assign bounds_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
      in_flight_q <= 1'b0;
      out_en_q    <= 1'b0;
    end else begin
      out_en_q    <= 1'b1;
      in_flight_q <= rd_issue;
      if (cmd_fire) begin
        cur_addr_q  <= cmd_addr;
        remaining_q <= cmd_len;
      end else if (wr_fire || rd_issue) begin
        cur_addr_q  <= cur_addr_q + ADDR_DEPTH'(1);
        remaining_q <= remaining_q - LEN_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if ((cmd_len == '0) || bounds_err)  state_d = ST_DONE;
          else if (cmd_write == DIR_WRITE)    state_d = ST_WRITE;
          else                                state_d = ST_READ;
        end
      end
      ST_WRITE: if (wr_fire && (remaining_q == LEN_W'(1)))  state_d = ST_DONE;
      ST_READ:  if (rd_issue && (remaining_q == LEN_W'(1))) state_d = ST_DRAIN;
      ST_DRAIN: if (!in_flight_q && (occupancy == 2'd0))    state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    rd_issue    = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    rf_en_write = 1'b0;
    rf_en_read  = 1'b0;
    rf_address  = '0;
    rf_data_in  = '0;
    case (state_q)
      ST_IDLE:  cmd_ready = out_en_q;
      ST_WRITE: begin
        wr_ready    = (remaining_q != '0);
        rf_en_write = wr_valid && (remaining_q != '0);
      end
      ST_READ: begin
        rd_issue   = (remaining_q != '0) && (occ_sum < occ_limit);
        rf_en_read = rd_issue;
      end
      ST_DONE: begin
        done = 1'b1;
`ifdef RF_BURST_BOUNDS_CHECK_EN
        err  = err_q;
`endif
      end
      default: ;
    endcase
    if (rf_en_write || rf_en_read) rf_address = cur_addr_q;
    if (rf_en_write)               rf_data_in = wr_data;
  end

  regfile_burst_master_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_skid (
    .clock     (clock),
    .rst_n     (rst_n),
    .push      (in_flight_q),
    .push_data (rf_data_out),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_regfile_burst_master.sv
// Directed bench for regfile_burst_master with a behavioural register file
// (registered read, one-cycle latency). Honours RF_BURST_BOUNDS_CHECK_EN.
module tb_regfile_burst_master;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [11:0] cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [23:0] wr_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [23:0] rd_data;
  logic        done;
  logic        err;
  logic [11:0] rf_address;
  logic        rf_en_write;
  logic        rf_en_read;
  logic [23:0] rf_data_in;
  logic [23:0] rf_data_out = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  regfile_burst_master dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .done        (done),
    .err         (err),
    .rf_address  (rf_address),
    .rf_en_write (rf_en_write),
    .rf_en_read  (rf_en_read),
    .rf_data_in  (rf_data_in),
    .rf_data_out (rf_data_out)
  );

  logic [23:0] mem [0:4095];
  always @(posedge clock) begin
    if (rf_en_write) mem[rf_address] <= rf_data_in;
    if (rf_en_read)  rf_data_out <= mem[rf_address];
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Event logs, sampled mid-cycle.
  logic [11:0] wr_addr_q [$];
  int          wr_cyc_q  [$];
  logic [23:0] rd_data_q [$];
  int          rd_cyc_q  [$];
  int          done_cnt = 0;
  int          both_cnt = 0;
  int          viol_cnt = 0;
  int          issue_cnt = 0;
  int          deliv_cnt = 0;
  int          lost = 0;

  always @(negedge clock) begin
    if (!rst_n) begin
      lost = issue_cnt - deliv_cnt;
    end else begin
      if (issue_cnt - deliv_cnt - lost > 2) viol_cnt++;
      if (rf_en_write && rf_en_read) both_cnt++;
      if (rf_en_write) begin
        wr_addr_q.push_back(rf_address);
        wr_cyc_q.push_back(cyc);
      end
      if (rf_en_read) issue_cnt++;
      if (rd_valid && rd_ready) begin
        rd_data_q.push_back(rd_data);
        rd_cyc_q.push_back(cyc);
        deliv_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic send_cmd(input logic w, input logic [11:0] a, input logic [11:0] l,
                          output int acc);
    bit ok = 0;
    acc = -1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (cmd_ready) begin
        acc = cyc; ok = 1;
        @(posedge clock); #1;
        break;
      end
      @(posedge clock); #1;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL cmd_accept: cmd_ready never seen (addr=%h len=%0d)", a, l);
    end
  endtask

  task automatic wait_done(input int max, output int dcyc, output logic derr);
    bit got = 0;
    dcyc = -1; derr = 1'bx;
    for (int k = 0; k < max; k++) begin
      @(negedge clock);
      if (done) begin
        dcyc = cyc; derr = err; got = 1;
        @(posedge clock); #1;
        break;
      end
      @(posedge clock); #1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL done_timeout: no done within %0d cycles", max);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic [11:0] len, input logic [23:0] d0,
                          output int acc);
    int i = 0;
    send_cmd(1'b1, a, len, acc);
    for (int k = 0; k < 40 && i < int'(len); k++) begin
      wr_valid = 1'b1;
      wr_data  = d0 + 24'(i);
      @(negedge clock);
      if (wr_ready) i++;
      @(posedge clock); #1;
    end
    wr_valid = 1'b0;
    wr_data  = '0;
    checks++;
    if (i != int'(len)) begin
      failures++;
      $display("FAIL write_feed: consumed %0d words, required %0d", i, len);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    checks++; if ({done, err} !== 2'b00) begin failures++; $display("FAIL reset_done_err: got %b want 00", {done, err}); end
    checks++; if ({rf_en_write, rf_en_read} !== 2'b00) begin failures++; $display("FAIL reset_enables: got %b want 00", {rf_en_write, rf_en_read}); end
    checks++; if (rf_address !== 12'h000 || rf_data_in !== 24'h0 || rd_data !== 24'h0) begin
      failures++; $display("FAIL reset_buses: addr=%h din=%h rd=%h want 0", rf_address, rf_data_in, rd_data);
    end
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(posedge clock); @(negedge clock);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL release_cmd_ready: got %b want 1", cmd_ready); end
    @(posedge clock); #1;
  endtask

  task automatic test_write;
    int acc, dcyc, base;
    logic derr;
    base = wr_addr_q.size();
    do_write(12'h010, 12'd4, 24'hA1, acc);
    wait_done(20, dcyc, derr);
    checks++;
    if (wr_addr_q.size() - base != 4) begin
      failures++; $display("FAIL write_count: got %0d want 4", wr_addr_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_q[base+i] !== 12'h010 + 12'(i) || wr_cyc_q[base+i] != acc + 1 + i) begin
          failures++;
          $display("FAIL write_beat%0d: addr=%h cyc=%0d want addr=%h cyc=%0d",
                   i, wr_addr_q[base+i], wr_cyc_q[base+i], 12'h010 + 12'(i), acc + 1 + i);
        end
        checks++;
        if (mem[12'h010 + 12'(i)] !== 24'hA1 + 24'(i)) begin
          failures++; $display("FAIL write_data%0d: got %h want %h", i, mem[12'h010 + 12'(i)], 24'hA1 + 24'(i));
        end
      end
    end
    checks++; if (dcyc != acc + 5) begin failures++; $display("FAIL write_done_cycle: got %0d want %0d", dcyc, acc + 5); end
    checks++; if (derr !== 1'b0) begin failures++; $display("FAIL write_err: got %b want 0", derr); end
  endtask

  task automatic test_read_back;
    int acc, dcyc, base, bb;
    logic derr;
    base = rd_data_q.size();
    bb = both_cnt;
    rd_ready = 1'b1;
    send_cmd(1'b0, 12'h010, 12'd4, acc);
    wait_done(30, dcyc, derr);
    rd_ready = 1'b0;
    checks++;
    if (rd_data_q.size() - base != 4) begin
      failures++; $display("FAIL readback_count: got %0d want 4", rd_data_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_data_q[base+i] !== 24'hA1 + 24'(i) || rd_cyc_q[base+i] != acc + 3 + i) begin
          failures++;
          $display("FAIL readback_word%0d: data=%h cyc=%0d want data=%h cyc=%0d",
                   i, rd_data_q[base+i], rd_cyc_q[base+i], 24'hA1 + 24'(i), acc + 3 + i);
        end
      end
    end
    checks++; if (dcyc != acc + 8) begin failures++; $display("FAIL readback_done_cycle: got %0d want %0d", dcyc, acc + 8); end
    checks++; if (both_cnt != bb) begin failures++; $display("FAIL readback_both_enables: %0d cycles want 0", both_cnt - bb); end
  endtask

  task automatic test_read_stall;
    int acc, dcyc, base, vb, bb;
    logic derr;
    bit got = 0;
    do_write(12'h100, 12'd8, 24'h5A0000, acc);
    wait_done(20, dcyc, derr);
    base = rd_data_q.size();
    vb = viol_cnt;
    bb = both_cnt;
    send_cmd(1'b0, 12'h100, 12'd8, acc);
    for (int k = 0; k < 100; k++) begin
      rd_ready = (k % 3 == 0);
      @(negedge clock);
      if (done) begin got = 1; @(posedge clock); #1; break; end
      @(posedge clock); #1;
    end
    rd_ready = 1'b0;
    checks++; if (!got) begin failures++; $display("FAIL stall_done: no done within 100 cycles"); end
    checks++;
    if (rd_data_q.size() - base != 8) begin
      failures++; $display("FAIL stall_count: got %0d want 8", rd_data_q.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rd_data_q[base+i] !== 24'h5A0000 + 24'(i)) begin
          failures++; $display("FAIL stall_word%0d: got %h want %h", i, rd_data_q[base+i], 24'h5A0000 + 24'(i));
        end
      end
    end
    checks++; if (viol_cnt != vb) begin failures++; $display("FAIL stall_occupancy: %0d cycles above 2 want 0", viol_cnt - vb); end
    checks++; if (both_cnt != bb) begin failures++; $display("FAIL stall_both_enables: %0d cycles want 0", both_cnt - bb); end
  endtask

  task automatic test_wrap;
    int acc, dcyc, base;
    logic derr;
    logic [11:0] exp_addr [4];
    exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'h000; exp_addr[3] = 12'h001;
    base = wr_addr_q.size();
`ifdef RF_BURST_BOUNDS_CHECK_EN
    send_cmd(1'b1, 12'hFFE, 12'd4, acc);
    wait_done(10, dcyc, derr);
    checks++; if (wr_addr_q.size() != base) begin failures++; $display("FAIL bounds_writes: got %0d want 0", wr_addr_q.size() - base); end
    checks++; if (derr !== 1'b1) begin failures++; $display("FAIL bounds_err: got %b want 1", derr); end
    checks++; if (dcyc != acc + 1) begin failures++; $display("FAIL bounds_done_cycle: got %0d want %0d", dcyc, acc + 1); end
`else
    do_write(12'hFFE, 12'd4, 24'hB1, acc);
    wait_done(20, dcyc, derr);
    checks++;
    if (wr_addr_q.size() - base != 4) begin
      failures++; $display("FAIL wrap_count: got %0d want 4", wr_addr_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_q[base+i] !== exp_addr[i]) begin
          failures++; $display("FAIL wrap_addr%0d: got %h want %h", i, wr_addr_q[base+i], exp_addr[i]);
        end
      end
    end
    checks++; if (mem[12'h001] !== 24'hB4) begin failures++; $display("FAIL wrap_data: got %h want b4", mem[12'h001]); end
    checks++; if (derr !== 1'b0) begin failures++; $display("FAIL wrap_err: got %b want 0", derr); end
`endif
  endtask

  task automatic test_len0;
    int acc, dcyc, wb, ib;
    logic derr;
    for (int d = 0; d < 2; d++) begin
      wb = wr_addr_q.size();
      ib = issue_cnt;
      send_cmd(d[0], 12'h123, 12'd0, acc);
      wait_done(10, dcyc, derr);
      checks++; if (dcyc != acc + 1) begin failures++; $display("FAIL len0_done_cycle dir=%0d: got %0d want %0d", d, dcyc, acc + 1); end
      checks++;
      if (wr_addr_q.size() != wb || issue_cnt != ib) begin
        failures++; $display("FAIL len0_enables dir=%0d: writes=%0d reads=%0d want 0", d, wr_addr_q.size() - wb, issue_cnt - ib);
      end
      checks++; if (derr !== 1'b0) begin failures++; $display("FAIL len0_err dir=%0d: got %b want 0", d, derr); end
    end
  endtask

  task automatic test_reset_mid;
    int acc, base, dc;
    base = rd_data_q.size();
    dc = done_cnt;
    rd_ready = 1'b1;
    send_cmd(1'b0, 12'h100, 12'd6, acc);
    repeat (4) @(posedge clock);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, wr_ready, rd_valid, done, rf_en_read, rf_en_write} !== 6'b0 || rd_data !== 24'h0) begin
      failures++;
      $display("FAIL midreset_outputs: rdy=%b wrdy=%b rv=%b done=%b ren=%b wen=%b rd=%h want 0",
               cmd_ready, wr_ready, rd_valid, done, rf_en_read, rf_en_write, rd_data);
    end
    checks++;
    if (rd_data_q.size() - base != 2) begin
      failures++; $display("FAIL midreset_delivered: got %0d want 2", rd_data_q.size() - base);
    end else begin
      checks++;
      if (rd_data_q[base] !== 24'h5A0000 || rd_data_q[base+1] !== 24'h5A0001) begin
        failures++; $display("FAIL midreset_words: got %h %h want 5a0000 5a0001", rd_data_q[base], rd_data_q[base+1]);
      end
    end
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL midreset_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (done_cnt != dc) begin failures++; $display("FAIL midreset_done: %0d pulses want 0", done_cnt - dc); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL midreset_flush: rd_valid=%b want 0", rd_valid); end
    rd_ready = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read_back;
    test_read_stall;
    test_wrap;
    test_len0;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
